// File: rtl/bf16_div_seq_pkg.sv
// Shared definitions for the bf16 divide back end: class flag bit positions,
// special-value magnitude patterns, FSM state encoding, exponent bias and the
// common bf16 classifier.
package bf16_div_seq_pkg;

  localparam int BF_NEXP = 8;
  localparam int BF_NSIG = 7;
  localparam int BF_BIAS = 127;
  localparam int BF_W    = BF_NEXP + BF_NSIG + 1;

  localparam int NFLAGS         = 6;
  localparam int FLAG_ZERO      = 0;
  localparam int FLAG_INF       = 1;
  localparam int FLAG_SNAN      = 2;
  localparam int FLAG_QNAN      = 3;
  localparam int FLAG_SUBNORMAL = 4;
  localparam int FLAG_NORMAL    = 5;

  // Magnitudes only (sign bit excluded); callers prepend the result sign.
  localparam logic [BF_W-2:0] MAG_ZERO = '0;
  localparam logic [BF_W-2:0] MAG_INF  = {{BF_NEXP{1'b1}}, {BF_NSIG{1'b0}}};
  localparam logic [BF_W-2:0] MAG_QNAN = {{BF_NEXP{1'b1}}, 1'b1, {(BF_NSIG-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPECIAL,
    ST_MUL,
    ST_NORM,
    ST_DONE
  } state_t;

  // One-hot class of a bf16 magnitude; the MSB of the fraction separates qNaN from sNaN.
  function automatic logic [NFLAGS-1:0] bf16_classify(input logic [BF_W-2:0] mag);
    logic [BF_NEXP-1:0] e;
    logic [BF_NSIG-1:0] f;
    logic [NFLAGS-1:0]  c;
    e = mag[BF_W-2:BF_NSIG];
    f = mag[BF_NSIG-1:0];
    c = '0;
    if (e == '0) begin
      if (f == '0) c[FLAG_ZERO] = 1'b1;
      else         c[FLAG_SUBNORMAL] = 1'b1;
    end else if (&e) begin
      if (f == '0)             c[FLAG_INF]  = 1'b1;
      else if (f[BF_NSIG-1])   c[FLAG_QNAN] = 1'b1;
      else                     c[FLAG_SNAN] = 1'b1;
    end else begin
      c[FLAG_NORMAL] = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/bf16_div_seq_mul.sv
// Sequential shift-add significand multiplier. start loads the operands;
// N cycles later the 2N-bit product sits in product. done is high during the
// cycle whose clock edge performs the final add/shift.
module bf16_seq_mul #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N);

  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           busy;

  assign done = busy && (cnt == CW'(N - 1));

  // Load on start, then one conditional add and shift per cycle while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
    end else if (start) begin
      mcand   <= {{N{1'b0}}, a};
      mplier  <= b;
      product <= '0;
      cnt     <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      if (mplier[0]) product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) busy <= 1'b0;
      else      cnt  <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/bf16_div_seq.sv
// bf16 divide back end: quotient = dividend * recip(divisor), using a
// multi-cycle shift-add significand multiplier and a normalise/round step.
// Optional macro BF16_DIV_RNE_EN selects round-to-nearest-even; without it
// the result is truncated. Subnormal dividends are treated as zero.
//
// state   | meaning
// IDLE    | waiting for an operation, in_ready high
// SPECIAL | NaN/Inf/zero operand, build the special result
// MUL     | significand multiply running (NSIG+1 cycles)
// NORM    | normalise, round, range check
// DONE    | result presented, waiting for out_ready
module bf16_div_seq
  import bf16_div_seq_pkg::*;
#(
  parameter int NEXP = BF_NEXP,
  parameter int NSIG = BF_NSIG,
  parameter int BIAS = BF_BIAS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NEXP+NSIG:0]   dividend,
  input  logic [NEXP+NSIG:0]   recip,
  input  logic [NFLAGS-1:0]    recip_flags,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NEXP+NSIG:0]   quotient,
  output logic [NFLAGS-1:0]    div_flags
);

  localparam int W   = NEXP + NSIG + 1;
  localparam int SW  = NSIG + 1;
  localparam int PW  = 2 * SW;
  localparam int EW  = NEXP + 2;
  localparam int LZW = $clog2(PW + 1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << NEXP) - 1);
  localparam logic signed [EW-1:0] EXP_ONE = EW'(1);

  state_t state;

  logic              accept, is_special;
  logic [NFLAGS-1:0] d_cls;
  logic              d_nan, d_inf, d_zero, r_nan, r_inf, r_zero, r_sub;
  logic [NEXP-1:0]   d_exp, r_exp;
  logic signed [EW-1:0] exp_sum;

  logic              sign_q, d_nan_q, d_inf_q, d_zero_q, r_nan_q, r_inf_q, r_zero_q;
  logic signed [EW-1:0] exp_sum_q;

  logic              mul_done;
  logic [PW-1:0]     product, shifted;
  logic [LZW-1:0]    lz;
  logic              lz_found;
  logic signed [EW-1:0] exp_n, exp_r;
  logic [NSIG-1:0]   frac_t, frac_r;
  logic              round_inc, rnd_carry;
  logic              unused_bits;

  logic [W-1:0]      spec_q, norm_q;
  logic [NFLAGS-1:0] spec_f, norm_f;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;

  assign d_cls  = bf16_classify(dividend[W-2:0]);
  assign d_nan  = d_cls[FLAG_SNAN] | d_cls[FLAG_QNAN];
  assign d_inf  = d_cls[FLAG_INF];
  assign d_zero = d_cls[FLAG_ZERO] | d_cls[FLAG_SUBNORMAL];
  assign r_nan  = recip_flags[FLAG_SNAN] | recip_flags[FLAG_QNAN];
  assign r_inf  = recip_flags[FLAG_INF];
  assign r_zero = recip_flags[FLAG_ZERO];
  assign r_sub  = recip_flags[FLAG_SUBNORMAL];
  assign is_special = d_nan | d_inf | d_zero | r_nan | r_inf | r_zero;

  assign d_exp   = dividend[W-2:NSIG];
  assign r_exp   = r_sub ? NEXP'(1) : recip[W-2:NSIG];
  assign exp_sum = $signed(EW'(d_exp)) + $signed(EW'(r_exp)) - $signed(EW'(BIAS));

  bf16_seq_mul #(.N(SW)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && !is_special),
    .a       ({1'b1, dividend[NSIG-1:0]}),
    .b       ({~r_sub, recip[NSIG-1:0]}),
    .done    (mul_done),
    .product (product)
  );

  // Leading-zero count of the product, capped at the significand width.
  always_comb begin
    lz       = '0;
    lz_found = 1'b0;
    for (int i = PW - 1; i >= 0; i--) begin
      if (!lz_found) begin
        if (product[i]) lz_found = 1'b1;
        else            lz = lz + LZW'(1);
      end
    end
    if (lz > LZW'(SW)) lz = LZW'(SW);
  end

  // After the shift the leading one sits in the MSB; the product already
  // carries one integer bit of headroom, hence the +1.
  assign shifted = product << lz;
  assign exp_n   = exp_sum_q + EXP_ONE - $signed(EW'(lz));
  assign frac_t  = shifted[PW-2 -: NSIG];

`ifdef BF16_DIV_RNE_EN
  logic guard, sticky;
  assign guard       = shifted[PW-2-NSIG];
  assign sticky      = |shifted[PW-3-NSIG:0];
  assign round_inc   = guard & (sticky | frac_t[0]);
  assign unused_bits = ^{shifted[PW-1], d_cls[FLAG_NORMAL], recip_flags[FLAG_NORMAL]};
`else
  assign round_inc   = 1'b0;
  assign unused_bits = ^{shifted[PW-1], shifted[PW-2-NSIG:0], d_cls[FLAG_NORMAL],
                         recip_flags[FLAG_NORMAL]};
`endif

  // A carry out of the fraction means 1.111.. rounded to 2.0: fraction is already zero.
  assign {rnd_carry, frac_r} = SW'({1'b0, frac_t}) + SW'(round_inc);
  assign exp_r = exp_n + $signed(EW'(rnd_carry));

  // Special-operand result, priority NaN > Inf*0 > Inf > zero.
  always_comb begin
    spec_q = {sign_q, MAG_ZERO};
    spec_f = '0;
    if (d_nan_q || r_nan_q || (d_inf_q && r_zero_q) || (d_zero_q && r_inf_q)) begin
      spec_q = {sign_q, MAG_QNAN};
      spec_f[FLAG_QNAN] = 1'b1;
    end else if (d_inf_q || r_inf_q) begin
      spec_q = {sign_q, MAG_INF};
      spec_f[FLAG_INF] = 1'b1;
    end else begin
      spec_f[FLAG_ZERO] = 1'b1;
    end
  end

  // Range check of the normalised result: overflow to Inf, underflow flushes to zero.
  always_comb begin
    norm_q = {sign_q, MAG_ZERO};
    norm_f = '0;
    if (exp_r >= EXP_MAX) begin
      norm_q = {sign_q, MAG_INF};
      norm_f[FLAG_INF] = 1'b1;
    end else if (exp_r < EXP_ONE) begin
      norm_f[FLAG_ZERO] = 1'b1;
    end else begin
      norm_q = {sign_q, exp_r[NEXP-1:0], frac_r};
      norm_f[FLAG_NORMAL] = 1'b1;
    end
  end

  // Control FSM with registered result outputs and operand capture on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      quotient  <= '0;
      div_flags <= '0;
      sign_q    <= 1'b0;
      exp_sum_q <= '0;
      d_nan_q   <= 1'b0;
      d_inf_q   <= 1'b0;
      d_zero_q  <= 1'b0;
      r_nan_q   <= 1'b0;
      r_inf_q   <= 1'b0;
      r_zero_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sign_q    <= dividend[W-1] ^ recip[W-1];
            exp_sum_q <= exp_sum;
            d_nan_q   <= d_nan;
            d_inf_q   <= d_inf;
            d_zero_q  <= d_zero;
            r_nan_q   <= r_nan;
            r_inf_q   <= r_inf;
            r_zero_q  <= r_zero;
            state     <= is_special ? ST_SPECIAL : ST_MUL;
          end
        end
        ST_SPECIAL: begin
          quotient  <= spec_q;
          div_flags <= spec_f;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_MUL: begin
          if (mul_done) state <= ST_NORM;
        end
        ST_NORM: begin
          quotient  <= norm_q;
          div_flags <= norm_f;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bf16_div_seq.sv
// Self-checking bench for bf16_div_seq: a vector table run through a
// scoreboard queue, plus backpressure and mid-operation reset sequences.
module tb_bf16_div_seq;
  import bf16_div_seq_pkg::*;

  typedef struct {
    logic [15:0] a;
    logic [15:0] r;
    logic [5:0]  rf;
    logic [15:0] q;
    logic [5:0]  f;
    int          lat;
  } vec_t;

  localparam logic [5:0] FZ = 6'(1 << FLAG_ZERO);
  localparam logic [5:0] FI = 6'(1 << FLAG_INF);
  localparam logic [5:0] FQ = 6'(1 << FLAG_QNAN);
  localparam logic [5:0] FS = 6'(1 << FLAG_SUBNORMAL);
  localparam logic [5:0] FN = 6'(1 << FLAG_NORMAL);

`ifdef BF16_DIV_RNE_EN
  localparam logic [15:0] Q_RND = 16'h4012;
`else
  localparam logic [15:0] Q_RND = 16'h4011;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] dividend, recip, quotient;
  logic [5:0]  recip_flags, div_flags;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t sb[$];
  vec_t vecs[18];

  always #5 clk = ~clk;

  bf16_div_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .recip       (recip),
    .recip_flags (recip_flags),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .div_flags   (div_flags)
  );

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] r, input logic [5:0] rf,
                              input logic [15:0] q, input logic [5:0] f, input int lat);
    vec_t v;
    v.a = a; v.r = r; v.rf = rf; v.q = q; v.f = f; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one operation, wait for out_valid, compare against the scoreboard head.
  task automatic issue(input vec_t v, input string tag);
    int   cyc;
    vec_t e;
    sb.push_back(v);
    @(negedge clk);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid    = 1'b1;
    dividend    = v.a;
    recip       = v.r;
    recip_flags = v.rf;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    n_vec++;
    e = sb.pop_front();
    if (!out_valid) begin
      n_err++;
      $display("FAIL %s timeout: no out_valid within %0d clocks", tag, cyc);
    end else begin
      check({tag, " quotient"}, 32'(quotient), 32'(e.q));
      check({tag, " flags"}, 32'(div_flags), 32'(e.f));
      check({tag, " latency"}, 32'(cyc), 32'(e.lat));
      check({tag, " in_ready in DONE"}, 32'(in_ready), 32'd0);
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, " out_valid cleared"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic stray;

    vecs[0]  = mk(16'h4000, 16'h3E80, FN, 16'h3F00, FN, 10);
    vecs[1]  = mk(16'h3FC0, 16'h3FC0, FN, 16'h4010, FN, 10);
    vecs[2]  = mk(16'hBFC0, 16'h3FC0, FN, 16'hC010, FN, 10);
    vecs[3]  = mk(16'h3FC1, 16'h3FC1, FN, Q_RND,    FN, 10);
    vecs[4]  = mk(16'h7F80, 16'h0000, FZ, 16'h7FC0, FQ, 2);
    vecs[5]  = mk(16'h7FC0, 16'h3F80, FN, 16'h7FC0, FQ, 2);
    vecs[6]  = mk(16'h7F00, 16'h7F00, FN, 16'h7F80, FI, 10);
    vecs[7]  = mk(16'h0080, 16'h0080, FN, 16'h0000, FZ, 10);
    vecs[8]  = mk(16'h0000, 16'h3F80, FN, 16'h0000, FZ, 2);
    vecs[9]  = mk(16'h8001, 16'h3F80, FN, 16'h8000, FZ, 2);
    vecs[10] = mk(16'h3F80, 16'h7F80, FI, 16'h7F80, FI, 2);
    vecs[11] = mk(16'h4040, 16'h3F00, FN, 16'h3FC0, FN, 10);
    vecs[12] = mk(16'h4000, 16'h0040, FS, 16'h0080, FN, 10);
    vecs[13] = mk(16'h3F80, 16'h0000, FZ, 16'h0000, FZ, 2);
    vecs[14] = mk(16'h7F80, 16'hFFC0, FQ, 16'hFFC0, FQ, 2);
    vecs[15] = mk(16'h0000, 16'h7F80, FI, 16'h7FC0, FQ, 2);
    vecs[16] = mk(16'hFF00, 16'h7F00, FN, 16'hFF80, FI, 10);
    vecs[17] = mk(16'hC000, 16'hBE80, FN, 16'h3F00, FN, 10);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    dividend = '0; recip = '0; recip_flags = '0;
    repeat (3) @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset div_flags", 32'(div_flags), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 18; i++) begin
      issue(vecs[i], $sformatf("vec%0d", i));
      release_result($sformatf("vec%0d", i));
    end

    // Backpressure: result held stable and no new operation accepted.
    out_ready = 1'b0;
    issue(vecs[0], "bp");
    in_valid = 1'b1; dividend = 16'h3FC0; recip = 16'h3FC0; recip_flags = FN;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp quotient stable", 32'(quotient), 32'h3F00);
      check("bp out_valid held", 32'(out_valid), 32'd1);
      check("bp in_ready low", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    release_result("bp");
    issue(vecs[1], "after bp");
    release_result("after bp");

    // Reset in the middle of the multiply discards the operation.
    @(negedge clk);
    in_valid = 1'b1; dividend = vecs[0].a; recip = vecs[0].r; recip_flags = vecs[0].rf;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_valid) stray = 1'b1;
    end
    check("no result after reset", 32'(stray), 32'd0);
    check("in_ready after reset", 32'(in_ready), 32'd1);
    issue(vecs[3], "post reset");
    release_result("post reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
